pipe_ctrl: RTL and testbench
============================

# pipe_ctrl

Central pipeline controller for the five-stage Beta core (IF, RF, EXEC, MEM, WB). It tracks destination registers in flight, detects hazards, and produces the per-stage instruction-register source selects (`ir_src_*`), the stall/freeze controls, the PC select and the operand bypass selects. It sequences the execute stage and its neighbours and owns the memory-wait freeze. It computes no data; all outputs are controls.

## Interface
Parameters:
- `NSTG_TRACK`, 3: number of downstream stages tracked (EXEC, MEM, WB); fixed at 3.
- `XP_REG`, 30: register written by the injected exception instruction.

Ports:
- `clk`, input, 1: core clock.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `ir_rf`, input, 32: instruction currently in the RF stage.
- `pc_rf_sup`, input, 1: PC[31] of the RF-stage instruction (supervisor bit).
- `illop_rf`, input, 1: the RF-stage opcode is illegal.
- `branch_taken_rf`, input, 1: the RF-stage BEQ/BNE/JMP resolves taken.
- `irq`, input, 1: interrupt request level, already synchronised.
- `dmem_req`, input, 1: the MEM stage is issuing a data access this cycle.
- `dmem_ready`, input, 1: the data memory completes the access this cycle.
- `stall_front`, output, 1: hold the PC, IF and RF registers.
- `freeze_all`, output, 1: hold every pipeline register.
- `ir_src_if`, `ir_src_rf`, `ir_src_exec`, `ir_src_mem`, output, 2 each: `IR_SRC_DATA`, `IR_SRC_NOP` or `IR_SRC_EXCEPT`.
- `pc_sel`, output, 3: `PC_SEL_INC`, `PC_SEL_BR`, `PC_SEL_JMP`, `PC_SEL_ILLOP` or `PC_SEL_XADR`.
- `a_byp_sel`, `b_byp_sel`, output, 2 each: `BYP_REG`, `BYP_EXEC`, `BYP_MEM` or `BYP_WB`.

## Operation
Register decode (Beta fields):
- `rc` = `ir[25:21]`, `ra` = `ir[20:16]`, `rb` = `ir[15:11]`.
- `rb` is a source only when `opcode[5:4]==2'b10`.
- ST (0x19) uses `rc` as its second source, in place of `rb`.
- Every opcode except ST and illegal opcodes writes `rc`. Writes to R31 are not tracked.
- A load is LD (0x18) or LDR (0x1F). JMP is 0x1B.

Scoreboard:
- One entry per tracked stage, each holding {valid, rc, is_ld}.
- Entries shift one stage on every clock edge where `freeze_all`=0.
- The entry entering EXEC depends on the RF action:
  - normal advance: decoded from `ir_rf`;
  - bubble: valid=0;
  - exception: {1, `XP_REG`, 0}.

FSM states are RUN and FREEZE.
- RUN → FREEZE when `dmem_req` && !`dmem_ready`.
- FREEZE → RUN when `dmem_ready`.
- In FREEZE: `freeze_all`=1 and `stall_front`=1. All `ir_src_*`=DATA, `pc_sel`=INC, and the scoreboard is held.
- The freeze is combinational in the first wait cycle, so the access is never lost.

RF-stage action priority, highest first (applies in RUN with no freeze):
1. Exception. Condition: `illop_rf`, or `irq` && !`pc_rf_sup`.
   - `ir_src_rf`=EXCEPT, `ir_src_if`=NOP.
   - `pc_sel`=ILLOP if `illop_rf`, else XADR. Illop wins over irq.
2. Load-use stall. Condition: an RF source equals the rc of a valid load entry in EXEC or MEM.
   - `stall_front`=1, `ir_src_rf`=NOP.
3. Taken branch. Condition: `branch_taken_rf`.
   - `ir_src_if`=NOP.
   - `pc_sel`=JMP for opcode 0x1B, else BR.
4. Otherwise all outputs take their DATA/INC/0 defaults.

Additional rules:
- A branch coincident with a stall is ignored; it re-resolves on the next cycle.
- `ir_src_exec` and `ir_src_mem` are always DATA outside reset.

Bypass (per source):
- Select the youngest valid non-load entry whose rc matches: EXEC, then MEM, then WB.
- WB also matches loads.
- No match, or source R31 → REG.

## Timing
- All outputs are combinational from the registered FSM/scoreboard state and the current inputs. Latency is zero cycles.
- A load-use stall lasts 1 cycle (load in MEM) or 2 cycles (load in EXEC).
- While `rst_n`=0:
  - scoreboard all invalid, state RUN;
  - `stall_front`=0, `freeze_all`=0;
  - all `ir_src_*`=NOP, `pc_sel`=INC, bypass selects=REG.
- Asserting reset mid-freeze returns the block to RUN immediately.

## Configuration
- `PIPE_BYPASS_EN` defined: bypassing works as described above.
- Not defined:
  - bypass selects are tied to REG;
  - any RF source that matches any valid entry in EXEC, MEM or WB (load or not) causes a stall under priority 2;
  - full interlock; results are visible only after write-back.

## Structure
- Add the following constants to `defines.v`: `PC_SEL_*`, `BYP_*`, the Beta opcode constants (LD, ST, JMP, LDR), and the existing `IR_SRC_*` encodings.
- Sub-module `pipe_scoreboard`: the 3-entry shift register with freeze hold, insert port and per-stage match outputs.
- `pipe_ctrl` itself holds the FSM, the priority logic and the bypass selection.

## Test plan
- ADD r1 then ADD r2,r1 back-to-back → `a_byp_sel`=EXEC, no stall. Without the macro: 3 stall cycles.
- LD r3 then SUB r4,r3 → 2 cycles of `stall_front`=1 with `ir_src_rf`=NOP, then `a_byp_sel`=WB.
- `dmem_req`=1 with `dmem_ready` low for 3 cycles → `freeze_all`=1 for exactly those 3 cycles; scoreboard unchanged; RUN after ready.
- `irq`=1 with `pc_rf_sup`=0 and a coincident load-use hazard → `ir_src_rf`=EXCEPT, `pc_sel`=XADR, no stall; the next instruction's R30 source bypasses from EXEC. With `pc_rf_sup`=1 → no exception.
- BEQ taken while its operand is a load in EXEC → stall first; BR redirect with `ir_src_if`=NOP only after the stall clears.
- Reset asserted during FREEZE → outputs take reset values asynchronously; after release, ADD r5 followed by a reader → no false bypass.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the five-stage Beta pipeline controller.
// Holds the IR source, PC select and bypass select encodings, the Beta
// opcode constants used by hazard decode, and the scoreboard entry type.
package pipe_ctrl_pkg;

  localparam logic [1:0] IR_SRC_DATA   = 2'd0;
  localparam logic [1:0] IR_SRC_NOP    = 2'd1;
  localparam logic [1:0] IR_SRC_EXCEPT = 2'd2;

  localparam logic [2:0] PC_SEL_INC   = 3'd0;
  localparam logic [2:0] PC_SEL_BR    = 3'd1;
  localparam logic [2:0] PC_SEL_JMP   = 3'd2;
  localparam logic [2:0] PC_SEL_ILLOP = 3'd3;
  localparam logic [2:0] PC_SEL_XADR  = 3'd4;

  localparam logic [1:0] BYP_REG  = 2'd0;
  localparam logic [1:0] BYP_EXEC = 2'd1;
  localparam logic [1:0] BYP_MEM  = 2'd2;
  localparam logic [1:0] BYP_WB   = 2'd3;

  localparam logic [5:0] OP_LD  = 6'h18;
  localparam logic [5:0] OP_ST  = 6'h19;
  localparam logic [5:0] OP_JMP = 6'h1B;
  localparam logic [5:0] OP_LDR = 6'h1F;

  localparam logic [4:0] REG_R31 = 5'd31;

  typedef enum logic {ST_RUN, ST_FREEZE} state_t;

  // One in-flight destination: written register and whether it is a load.
  typedef struct packed {
    logic       valid;
    logic [4:0] rc;
    logic       is_ld;
  } sb_entry_t;

  function automatic logic is_load(input logic [5:0] op);
    return (op == OP_LD) || (op == OP_LDR);
  endfunction

endpackage

// File: rtl/pipe_scoreboard.sv
// Destination scoreboard for EXEC/MEM/WB: a shift register of in-flight
// writes that holds while the pipeline is frozen, plus per-stage source
// match flags for the two RF-stage operands.
module pipe_scoreboard
  import pipe_ctrl_pkg::*;
#(
  parameter int NSTG = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            hold,
  input  sb_entry_t       ins,
  input  logic [4:0]      src_a,
  input  logic            src_a_vld,
  input  logic [4:0]      src_b,
  input  logic            src_b_vld,
  output logic [NSTG-1:0] match_a,
  output logic [NSTG-1:0] match_b,
  output logic [NSTG-1:0] is_ld
);

  sb_entry_t stage_reg [NSTG];

  // Shift entries one stage downstream on every unfrozen edge; index 0 is EXEC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NSTG; i++) stage_reg[i] <= '0;
    end else if (!hold) begin
      stage_reg[0] <= ins;
      for (int i = 1; i < NSTG; i++) stage_reg[i] <= stage_reg[i-1];
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NSTG; gi++) begin : g_match
      assign match_a[gi] = stage_reg[gi].valid && src_a_vld && (stage_reg[gi].rc == src_a);
      assign match_b[gi] = stage_reg[gi].valid && src_b_vld && (stage_reg[gi].rc == src_b);
      assign is_ld[gi]   = stage_reg[gi].is_ld;
    end
  endgenerate

endmodule

// File: rtl/pipe_ctrl.sv
// Central pipeline controller for the five-stage Beta core.
// Owns the memory-wait freeze FSM, the RF-stage action priority
// (exception > load-use stall > taken branch) and operand bypass selects.
// Optional feature: define PIPE_BYPASS_EN to enable operand bypassing;
// without it the controller interlocks until results reach write-back.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int NSTG_TRACK = 3,
  parameter int XP_REG     = 30
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] ir_rf,
  input  logic        pc_rf_sup,
  input  logic        illop_rf,
  input  logic        branch_taken_rf,
  input  logic        irq,
  input  logic        dmem_req,
  input  logic        dmem_ready,
  output logic        stall_front,
  output logic        freeze_all,
  output logic [1:0]  ir_src_if,
  output logic [1:0]  ir_src_rf,
  output logic [1:0]  ir_src_exec,
  output logic [1:0]  ir_src_mem,
  output logic [2:0]  pc_sel,
  output logic [1:0]  a_byp_sel,
  output logic [1:0]  b_byp_sel
);

  state_t state_reg, state_next;

  logic [5:0] op;
  logic [4:0] rc, ra, rb, src_b;
  logic       op_is_st, src_a_vld, src_b_vld;
  logic       exc, hazard, freeze_now;
  sb_entry_t  dec_entry, exc_entry, ins;
  logic [NSTG_TRACK-1:0] match_a, match_b, sb_ld;
  logic [1:0] byp_a, byp_b;
  logic       unused_bits;

  assign op        = ir_rf[31:26];
  assign rc        = ir_rf[25:21];
  assign ra        = ir_rf[20:16];
  assign rb        = ir_rf[15:11];
  assign op_is_st  = (op == OP_ST);
  // ST reads rc as its second operand; only the 10xxxx class reads rb.
  assign src_b     = op_is_st ? rc : rb;
  assign src_a_vld = (ra != REG_R31);
  assign src_b_vld = ((op[5:4] == 2'b10) || op_is_st) && (src_b != REG_R31);

  assign dec_entry = {(!op_is_st && !illop_rf && (rc != REG_R31)), rc, is_load(op)};
  assign exc_entry = {1'b1, 5'(XP_REG), 1'b0};
  assign exc       = illop_rf || (irq && !pc_rf_sup);

  // Freeze starts combinationally on the first unready cycle and lasts until ready.
  assign freeze_now = (state_reg == ST_RUN) ? (dmem_req && !dmem_ready) : !dmem_ready;

  pipe_scoreboard #(.NSTG(NSTG_TRACK)) u_sb (
    .clk       (clk),
    .rst_n     (rst_n),
    .hold      (freeze_all),
    .ins       (ins),
    .src_a     (ra),
    .src_a_vld (src_a_vld),
    .src_b     (src_b),
    .src_b_vld (src_b_vld),
    .match_a   (match_a),
    .match_b   (match_b),
    .is_ld     (sb_ld)
  );

`ifdef PIPE_BYPASS_EN
  // Youngest non-load producer wins; WB may forward load data as well.
  function automatic logic [1:0] pick_byp(input logic [NSTG_TRACK-1:0] m,
                                          input logic [NSTG_TRACK-1:0] ld);
    if (m[0] && !ld[0])      return BYP_EXEC;
    else if (m[1] && !ld[1]) return BYP_MEM;
    else if (m[2])           return BYP_WB;
    else                     return BYP_REG;
  endfunction

  // Only loads still in EXEC or MEM cannot be forwarded in time.
  assign hazard      = |((match_a[1:0] | match_b[1:0]) & sb_ld[1:0]);
  assign byp_a       = pick_byp(match_a, sb_ld);
  assign byp_b       = pick_byp(match_b, sb_ld);
  assign unused_bits = ^{ir_rf[10:0], sb_ld[NSTG_TRACK-1]};
`else
  // Full interlock: any in-flight writer of a source holds the RF stage.
  assign hazard      = |(match_a | match_b);
  assign byp_a       = BYP_REG;
  assign byp_b       = BYP_REG;
  assign unused_bits = ^{ir_rf[10:0], sb_ld};
`endif

  // FSM state register; reset drops straight back to RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= ST_RUN;
    else        state_reg <= state_next;
  end

  // Next state, freeze/stall controls, IR source and PC selects by RF-stage priority.
  always_comb begin
    state_next  = freeze_now ? ST_FREEZE : ST_RUN;
    freeze_all  = 1'b0;
    stall_front = 1'b0;
    ir_src_if   = IR_SRC_DATA;
    ir_src_rf   = IR_SRC_DATA;
    ir_src_exec = IR_SRC_DATA;
    ir_src_mem  = IR_SRC_DATA;
    pc_sel      = PC_SEL_INC;
    ins         = dec_entry;
    if (!rst_n) begin
      state_next  = ST_RUN;
      ir_src_if   = IR_SRC_NOP;
      ir_src_rf   = IR_SRC_NOP;
      ir_src_exec = IR_SRC_NOP;
      ir_src_mem  = IR_SRC_NOP;
    end else if (freeze_now) begin
      freeze_all  = 1'b1;
      stall_front = 1'b1;
    end else if (exc) begin
      ir_src_rf = IR_SRC_EXCEPT;
      ir_src_if = IR_SRC_NOP;
      pc_sel    = illop_rf ? PC_SEL_ILLOP : PC_SEL_XADR;
      ins       = exc_entry;
    end else if (hazard) begin
      // A coincident taken branch is dropped here and re-resolves next cycle.
      stall_front = 1'b1;
      ir_src_rf   = IR_SRC_NOP;
      ins         = '0;
    end else if (branch_taken_rf) begin
      ir_src_if = IR_SRC_NOP;
      pc_sel    = (op == OP_JMP) ? PC_SEL_JMP : PC_SEL_BR;
    end
  end

  // Bypass selects, forced to the register file while in reset.
  always_comb begin
    a_byp_sel = rst_n ? byp_a : BYP_REG;
    b_byp_sel = rst_n ? byp_b : BYP_REG;
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios followed by random
// instruction/interrupt/memory-wait traffic, all checked against a
// behavioural model of in-flight writers kept by the bench.
module tb_pipe_ctrl;
  import pipe_ctrl_pkg::*;

`ifdef PIPE_BYPASS_EN
  localparam bit BYP_ON = 1'b1;
`else
  localparam bit BYP_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] ir_rf = '0;
  logic        pc_rf_sup = 1'b0, illop_rf = 1'b0, branch_taken_rf = 1'b0;
  logic        irq = 1'b0, dmem_req = 1'b0, dmem_ready = 1'b1;
  logic        stall_front, freeze_all;
  logic [1:0]  ir_src_if, ir_src_rf, ir_src_exec, ir_src_mem;
  logic [2:0]  pc_sel;
  logic [1:0]  a_byp_sel, b_byp_sel;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: writers in flight, youngest first (0 = one cycle after RF).
  bit         m_v  [3];
  logic [4:0] m_rc [3];
  bit         m_ld [3];

  always #5 clk = ~clk;

  pipe_ctrl #(.NSTG_TRACK(3), .XP_REG(30)) dut (
    .clk(clk), .rst_n(rst_n), .ir_rf(ir_rf), .pc_rf_sup(pc_rf_sup),
    .illop_rf(illop_rf), .branch_taken_rf(branch_taken_rf), .irq(irq),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .stall_front(stall_front), .freeze_all(freeze_all),
    .ir_src_if(ir_src_if), .ir_src_rf(ir_src_rf),
    .ir_src_exec(ir_src_exec), .ir_src_mem(ir_src_mem),
    .pc_sel(pc_sel), .a_byp_sel(a_byp_sel), .b_byp_sel(b_byp_sel)
  );

  task automatic chk(input string tag, input logic [2:0] got, input logic [2:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] c,
                                     input logic [4:0] a, input logic [4:0] b);
    return {op, c, a, b, 11'd0};
  endfunction

  // Would reading s now see a result that is not yet obtainable?
  function automatic bit must_wait(input logic [4:0] s, input bit en);
    if (!en) return 1'b0;
    for (int k = 0; k < 3; k++)
      if (m_v[k] && m_rc[k] == s && (BYP_ON ? (k < 2 && m_ld[k]) : 1'b1)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [1:0] want_byp(input logic [4:0] s, input bit en);
    if (!en || !BYP_ON) return BYP_REG;
    for (int k = 0; k < 3; k++)
      if (m_v[k] && m_rc[k] == s && (!m_ld[k] || k == 2))
        return (k == 0) ? BYP_EXEC : (k == 1) ? BYP_MEM : BYP_WB;
    return BYP_REG;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin m_v[k] = 1'b0; m_rc[k] = '0; m_ld[k] = 1'b0; end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_stall"},  {2'b0, stall_front}, 3'd0);
    chk({tag, "_freeze"}, {2'b0, freeze_all},  3'd0);
    chk({tag, "_src_if"},   {1'b0, ir_src_if},   {1'b0, IR_SRC_NOP});
    chk({tag, "_src_rf"},   {1'b0, ir_src_rf},   {1'b0, IR_SRC_NOP});
    chk({tag, "_src_exec"}, {1'b0, ir_src_exec}, {1'b0, IR_SRC_NOP});
    chk({tag, "_src_mem"},  {1'b0, ir_src_mem},  {1'b0, IR_SRC_NOP});
    chk({tag, "_pc_sel"},   pc_sel, PC_SEL_INC);
    chk({tag, "_a_byp"},    {1'b0, a_byp_sel}, {1'b0, BYP_REG});
    chk({tag, "_b_byp"},    {1'b0, b_byp_sel}, {1'b0, BYP_REG});
  endtask

  bit m_wait = 1'b0;

  // One cycle: drive at negedge, check just after, advance model at posedge.
  task automatic step(input logic [31:0] ir, input bit sup, input bit il, input bit br,
                      input bit iq, input bit rq, input bit rd);
    logic [5:0] op;
    logic [4:0] rc, ra, sb;
    bit         b_en, frz, exc, haz, nv, nl;
    logic [4:0] nrc;
    logic [1:0] e_if, e_rf;
    logic [2:0] e_pc;
    bit         e_stall;
    @(negedge clk);
    ir_rf = ir; pc_rf_sup = sup; illop_rf = il; branch_taken_rf = br;
    irq = iq; dmem_req = rq; dmem_ready = rd;
    #1;
    op = ir[31:26]; rc = ir[25:21]; ra = ir[20:16];
    sb   = (op == OP_ST) ? rc : ir[15:11];
    b_en = (op[5:4] == 2'b10 || op == OP_ST) && sb != 5'd31;
    frz  = m_wait ? !rd : (rq && !rd);
    exc  = il || (iq && !sup);
    haz  = must_wait(ra, ra != 5'd31) || must_wait(sb, b_en);
    e_if = IR_SRC_DATA; e_rf = IR_SRC_DATA; e_pc = PC_SEL_INC; e_stall = frz;
    nv = (op != OP_ST) && rc != 5'd31; nrc = rc; nl = (op == OP_LD || op == OP_LDR);
    if (frz) begin
    end else if (exc) begin
      e_rf = IR_SRC_EXCEPT; e_if = IR_SRC_NOP; e_pc = il ? PC_SEL_ILLOP : PC_SEL_XADR;
      nv = 1'b1; nrc = 5'd30; nl = 1'b0;
    end else if (haz) begin
      e_stall = 1'b1; e_rf = IR_SRC_NOP; nv = 1'b0;
    end else if (br) begin
      e_if = IR_SRC_NOP; e_pc = (op == OP_JMP) ? PC_SEL_JMP : PC_SEL_BR;
    end
    chk("stall",    {2'b0, stall_front}, {2'b0, e_stall});
    chk("freeze",   {2'b0, freeze_all},  {2'b0, frz});
    chk("src_if",   {1'b0, ir_src_if},   {1'b0, e_if});
    chk("src_rf",   {1'b0, ir_src_rf},   {1'b0, e_rf});
    chk("src_exec", {1'b0, ir_src_exec}, {1'b0, IR_SRC_DATA});
    chk("src_mem",  {1'b0, ir_src_mem},  {1'b0, IR_SRC_DATA});
    chk("pc_sel",   pc_sel, e_pc);
    chk("a_byp",    {1'b0, a_byp_sel}, {1'b0, want_byp(ra, ra != 5'd31)});
    chk("b_byp",    {1'b0, b_byp_sel}, {1'b0, want_byp(sb, b_en)});
    @(posedge clk);
    if (!frz) begin
      for (int k = 2; k > 0; k--) begin m_v[k] = m_v[k-1]; m_rc[k] = m_rc[k-1]; m_ld[k] = m_ld[k-1]; end
      m_v[0] = nv; m_rc[0] = nrc; m_ld[0] = nl;
    end
    m_wait = frz;
  endtask

  logic [5:0] ops  [8] = '{6'h20, 6'h21, 6'h30, 6'h18, 6'h19, 6'h1F, 6'h1B, 6'h1C};
  logic [4:0] regs [5] = '{5'd1, 5'd2, 5'd3, 5'd30, 5'd31};

  initial begin
    model_reset();
    // Reset with an illegal opcode and a memory wait pending.
    illop_rf = 1'b1; dmem_req = 1'b1; dmem_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_reset("reset");
    rst_n = 1'b1;

    // ADD r1 then ADD r2,r1: bypass from EXEC, or interlock without bypassing.
    step(mk(6'h20, 5'd1, 5'd2, 5'd3), 0, 0, 0, 0, 0, 1);
    repeat (4) step(mk(6'h20, 5'd2, 5'd1, 5'd1), 0, 0, 0, 0, 0, 1);

    // LD r3 then SUB r4,r3.
    step(mk(OP_LD, 5'd3, 5'd2, 5'd0), 0, 0, 0, 0, 0, 1);
    repeat (4) step(mk(6'h21, 5'd4, 5'd3, 5'd2), 0, 0, 0, 0, 0, 1);

    // Three-cycle memory wait, then ready.
    repeat (3) step(mk(6'h20, 5'd5, 5'd4, 5'd4), 0, 0, 0, 0, 1, 0);
    step(mk(6'h20, 5'd5, 5'd4, 5'd4), 0, 0, 0, 0, 1, 1);

    // Interrupt over a load-use hazard, then an R30 reader; supervisor masks irq.
    step(mk(OP_LD, 5'd6, 5'd1, 5'd0), 0, 0, 0, 0, 0, 1);
    step(mk(6'h20, 5'd7, 5'd6, 5'd6), 0, 0, 0, 1, 0, 1);
    step(mk(6'h20, 5'd8, 5'd30, 5'd30), 1, 0, 0, 1, 0, 1);

    // Taken BEQ whose operand is a load in EXEC.
    step(mk(OP_LD, 5'd9, 5'd1, 5'd0), 0, 0, 0, 0, 0, 1);
    repeat (3) step(mk(6'h1C, 5'd10, 5'd9, 5'd0), 0, 0, 1, 0, 0, 1);

    // Reset in the middle of a freeze, then ADD r5 and a reader.
    step(mk(6'h20, 5'd5, 5'd1, 5'd1), 0, 0, 0, 0, 1, 0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset("rst_frz");
    model_reset(); m_wait = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    step(mk(6'h20, 5'd6, 5'd5, 5'd5), 0, 0, 0, 0, 0, 1);
    step(mk(6'h20, 5'd5, 5'd1, 5'd1), 0, 0, 0, 0, 0, 1);
    step(mk(6'h20, 5'd6, 5'd5, 5'd5), 0, 0, 0, 0, 0, 1);

    // Random traffic over a small register set to provoke hazards.
    for (int i = 0; i < 600; i++)
      step(mk(ops[$urandom_range(0, 7)], regs[$urandom_range(0, 4)],
              regs[$urandom_range(0, 4)], regs[$urandom_range(0, 4)]),
           1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) != 0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
